// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: round-robin two-master Wishbone arbiter with outstanding-transfer tracking and ack timeout abort
// Ports: i_clk/i_rst clock and sync reset; i_mN_*/o_mN_* master N Wishbone port (N = 0 CPU, 1 DMA);
//        o_s_*/i_s_* shared slave-side bus; o_grant one-hot owner; o_timeout abort pulse.
module wb_master_arbiter #(
    parameter int TIMEOUT = 1024,
    parameter int MAX_OUT = 7
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    input  logic [3:0]  i_m0_sel,
    output logic        o_m0_stall,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic [31:0] o_m0_data,
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    input  logic [3:0]  i_m1_sel,
    output logic        o_m1_stall,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [31:0] o_m1_data,
    output logic        o_s_cyc,
    output logic        o_s_stb,
    output logic        o_s_we,
    output logic [31:0] o_s_addr,
    output logic [31:0] o_s_data,
    output logic [3:0]  o_s_sel,
    input  logic        i_s_stall,
    input  logic        i_s_ack,
    input  logic [31:0] i_s_data,
    output logic [1:0]  o_grant,
    output logic        o_timeout
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;
    state_t      r_state;
    logic        r_last;
    logic [2:0]  r_out;
    logic [15:0] r_tcount;
    logic [1:0]  r_grant;
    logic        w_own, w_sel1, w_cyc, w_full, w_acc, w_ack, w_abort;
    logic [2:0]  w_out_next;
    logic [15:0] w_tnext;
    always_comb begin
        w_own      = (r_state == OWN0) || (r_state == OWN1);
        w_sel1     = r_state == OWN1;
        w_cyc      = w_sel1 ? i_m1_cyc : i_m0_cyc;
        w_full     = r_out == 3'(MAX_OUT);
        o_s_cyc    = w_own & w_cyc;
        o_s_stb    = w_own & (w_sel1 ? i_m1_stb : i_m0_stb) & (r_out < 3'(MAX_OUT));
        o_s_we     = w_own & (w_sel1 ? i_m1_we : i_m0_we);
        o_s_addr   = !w_own ? 32'd0 : w_sel1 ? i_m1_addr : i_m0_addr;
        o_s_data   = !w_own ? 32'd0 : w_sel1 ? i_m1_data : i_m0_data;
        o_s_sel    = !w_own ? 4'd0 : w_sel1 ? i_m1_sel : i_m0_sel;
        o_m0_stall = (r_state != OWN0) | i_s_stall | w_full;
        o_m1_stall = (r_state != OWN1) | i_s_stall | w_full;
        o_m0_ack   = (r_state == OWN0) & i_s_ack;
        o_m1_ack   = (r_state == OWN1) & i_s_ack;
        o_m0_err   = (r_state == ABORT) & !r_last;
        o_m1_err   = (r_state == ABORT) & r_last;
        o_m0_data  = i_s_data;
        o_m1_data  = i_s_data;
        o_timeout  = r_state == ABORT;
        o_grant    = r_grant;
        w_acc      = o_s_stb & !i_s_stall;
        // acks with nothing pending are ignored so the counter cannot wrap
        w_ack      = i_s_ack & (r_out != 3'd0);
        w_out_next = r_out + 3'(w_acc) - 3'(w_ack);
        w_tnext    = (i_s_ack || r_out == 3'd0) ? 16'd0 : r_tcount + 16'd1;
        // ack in the same cycle clears w_tnext, so the ack beats the abort
        w_abort    = w_tnext == 16'(TIMEOUT - 1);
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_last   <= 1'b1;
            r_out    <= 3'd0;
            r_tcount <= 16'd0;
            r_grant  <= 2'b00;
        end else begin
            r_out    <= 3'd0;
            r_tcount <= 16'd0;
            r_grant  <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (i_m0_cyc && (!i_m1_cyc || r_last)) begin
                        r_state <= OWN0;
                        r_last  <= 1'b0;
                        r_grant <= 2'b01;
                    end else if (i_m1_cyc) begin
                        r_state <= OWN1;
                        r_last  <= 1'b1;
                        r_grant <= 2'b10;
                    end
                end
                OWN0, OWN1: begin
                    if (!w_cyc) r_state <= IDLE;
                    else if (w_abort) r_state <= ABORT;
                    else begin
                        r_out    <= w_out_next;
                        r_tcount <= w_tnext;
                        r_grant  <= r_grant;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_master_arbiter.sv
// tb_wb_master_arbiter: directed self-checking bench for wb_master_arbiter (TIMEOUT=16, MAX_OUT=2)
module tb_wb_master_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_data = 0, m1_addr = 0, m1_data = 0;
    logic [3:0]  m0_sel = 0, m1_sel = 0;
    logic        m0_stall, m0_ack, m0_err, m1_stall, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_sel;
    logic        s_stall = 0, s_ack = 0;
    logic [31:0] s_rdata = 0;
    logic [1:0]  grant;
    logic        timeout;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    wb_master_arbiter #(.TIMEOUT(16), .MAX_OUT(2)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
        .i_m0_data(m0_data), .i_m0_sel(m0_sel), .o_m0_stall(m0_stall), .o_m0_ack(m0_ack),
        .o_m0_err(m0_err), .o_m0_data(m0_rdata),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
        .i_m1_data(m1_data), .i_m1_sel(m1_sel), .o_m1_stall(m1_stall), .o_m1_ack(m1_ack),
        .o_m1_err(m1_err), .o_m1_data(m1_rdata),
        .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_addr(s_addr),
        .o_s_data(s_wdata), .o_s_sel(s_sel), .i_s_stall(s_stall), .i_s_ack(s_ack),
        .i_s_data(s_rdata), .o_grant(grant), .o_timeout(timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // reset held for three edges
        repeat (3) step();
        #1;
        chk("rst_s_cyc", 32'(s_cyc), 0);
        chk("rst_s_stb", 32'(s_stb), 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_m0_stall", 32'(m0_stall), 1);
        chk("rst_m1_stall", 32'(m1_stall), 1);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_timeout", 32'(timeout), 0);
        rst = 0;

        // single CPU read, acked two cycles after acceptance
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h100; m0_sel = 4'hf;
        #1;
        chk("rd_idle_s_cyc", 32'(s_cyc), 0);
        chk("rd_idle_stall", 32'(m0_stall), 1);
        step(); #1;
        chk("rd_grant", 32'(grant), 32'h1);
        chk("rd_s_cyc", 32'(s_cyc), 1);
        chk("rd_s_stb", 32'(s_stb), 1);
        chk("rd_s_addr", s_addr, 32'h100);
        chk("rd_stall", 32'(m0_stall), 0);
        step(); m0_stb = 0; #1;
        chk("rd_wait_ack", 32'(m0_ack), 0);
        step(); s_ack = 1; s_rdata = 32'hDEADBEEF; #1;
        chk("rd_ack", 32'(m0_ack), 1);
        chk("rd_data", m0_rdata, 32'hDEADBEEF);
        chk("rd_m1_ack", 32'(m1_ack), 0);
        step(); s_ack = 0; s_rdata = 0; m0_cyc = 0; #1;
        chk("rd_drop_s_cyc", 32'(s_cyc), 0);
        step(); #1;
        chk("rd_idle_grant", 32'(grant), 0);
        chk("rd_idle_stall2", 32'(m0_stall), 1);

        // contention: last served was m0, so m1 wins first, then alternation
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 32'hA0;
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_addr = 32'hB0;
        for (int r = 0; r < 4; r++) begin
            #1;
            chk("ct_idle_grant", 32'(grant), 0);
            step(); #1;
            chk("ct_grant", 32'(grant), (r % 2 == 0) ? 32'h2 : 32'h1);
            chk("ct_addr", s_addr, (r % 2 == 0) ? 32'hB0 : 32'hA0);
            chk("ct_we", 32'(s_we), 1);
            step();
            if (r % 2 == 0) m1_stb = 0; else m0_stb = 0;
            s_ack = 1; #1;
            chk("ct_owner_ack", 32'((r % 2 == 0) ? m1_ack : m0_ack), 1);
            chk("ct_other_stall", 32'((r % 2 == 0) ? m0_stall : m1_stall), 1);
            chk("ct_other_ack", 32'((r % 2 == 0) ? m0_ack : m1_ack), 0);
            step(); s_ack = 0;
            if (r % 2 == 0) m1_cyc = 0; else m0_cyc = 0;
            #1;
            chk("ct_release", 32'(s_cyc), 0);
            step();
            if (r == 3) begin
                m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
            end else if (r % 2 == 0) begin
                m1_cyc = 1; m1_stb = 1;
            end else begin
                m0_cyc = 1; m0_stb = 1;
            end
        end
        m0_we = 0; m1_we = 0;

        // pipelined m1 burst against MAX_OUT = 2
        m1_cyc = 1; m1_stb = 1; m1_addr = 32'hC0;
        step(); #1;
        chk("bu_grant", 32'(grant), 32'h2);
        chk("bu_c1_stall", 32'(m1_stall), 0);
        step(); #1;
        chk("bu_c2_stb", 32'(s_stb), 1);
        chk("bu_c2_stall", 32'(m1_stall), 0);
        step(); #1;
        chk("bu_full_stall", 32'(m1_stall), 1);
        chk("bu_full_stb", 32'(s_stb), 0);
        step(); s_ack = 1; #1;
        chk("bu_ack1", 32'(m1_ack), 1);
        chk("bu_ack1_stall", 32'(m1_stall), 1);
        step(); s_ack = 0; #1;
        chk("bu_c5_stall", 32'(m1_stall), 0);
        step(); s_ack = 1; #1;
        chk("bu_ack2", 32'(m1_ack), 1);
        chk("bu_c6_stall", 32'(m1_stall), 1);
        step(); #1;
        chk("bu_ack3", 32'(m1_ack), 1);
        chk("bu_c7_stall", 32'(m1_stall), 0);
        step(); m1_stb = 0; #1;
        chk("bu_ack4", 32'(m1_ack), 1);
        step(); s_ack = 0; m1_stb = 1; #1;
        chk("bu_empty_stall", 32'(m1_stall), 0);
        step(); #1;
        chk("bu_refill_stall", 32'(m1_stall), 0);
        step(); #1;
        chk("bu_refull_stall", 32'(m1_stall), 1);
        m1_cyc = 0; m1_stb = 0;
        step();

        // timeout: m0 strobe never acked while m1 waits
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1;
        step(); #1;
        chk("to_grant", 32'(grant), 32'h1);
        step(); m0_stb = 0;
        for (int j = 1; j <= 15; j++) begin
            #1;
            chk("to_no_err", 32'({m0_err, timeout}), 0);
            step();
        end
        #1;
        chk("to_err", 32'(m0_err), 1);
        chk("to_pulse", 32'(timeout), 1);
        chk("to_s_cyc", 32'(s_cyc), 0);
        chk("to_m1_err", 32'(m1_err), 0);
        chk("to_stall", 32'(m0_stall), 1);
        m0_cyc = 0;
        step(); #1;
        chk("to_idle", 32'({grant, timeout, m0_err}), 0);
        step(); #1;
        chk("to_m1_next", 32'(grant), 32'h2);
        m1_cyc = 0;
        step();

        // ack lands in the last cycle before the abort would fire
        m0_cyc = 1; m0_stb = 1;
        step(); step(); m0_stb = 0;
        for (int j = 1; j <= 14; j++) step();
        s_ack = 1; #1;
        chk("bd_ack", 32'(m0_ack), 1);
        chk("bd_no_err", 32'(m0_err), 0);
        step(); s_ack = 0; #1;
        chk("bd_no_timeout", 32'(timeout), 0);
        chk("bd_still_owned", 32'(grant), 32'h1);
        chk("bd_s_cyc", 32'(s_cyc), 1);
        m0_cyc = 0;
        step();

        // reset during OWN1 with two transfers outstanding
        m1_cyc = 1; m1_stb = 1;
        step(); step(); step(); #1;
        chk("mr_grant", 32'(grant), 32'h2);
        chk("mr_full", 32'(m1_stall), 1);
        rst = 1; m0_cyc = 1;
        step(); #1;
        chk("mr_grant_rst", 32'(grant), 0);
        chk("mr_s_cyc", 32'({s_cyc, s_stb}), 0);
        chk("mr_s_addr", s_addr, 0);
        chk("mr_stalls", 32'({m0_stall, m1_stall}), 32'h3);
        rst = 0; m1_stb = 0;
        step(); #1;
        chk("mr_m0_first", 32'(grant), 32'h1);
        chk("mr_cleared", 32'(m0_stall), 0);
        m0_cyc = 0; m1_cyc = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_master_arbiter.md
# wb_master_arbiter

Two-master Wishbone arbiter that shares the single pipelined Wishbone bus in front of the slave address decoder (BRAM / SDRAM / peripherals) between the picorv32 CPU (master 0) and a second bus master such as the DMA engine (master 1). It grants the bus with round-robin fairness and holds each grant for the owner's whole `cyc` cycle. It tracks outstanding transfers and aborts any cycle whose slave stops acknowledging, so a hung slave cannot lock up the system.

## Interface
Parameters:
- `TIMEOUT`, default 1024: cycles without an ack, while a transfer is outstanding, before the cycle is aborted. Legal range 2..65535.
- `MAX_OUT`, default 7: maximum outstanding (accepted, un-acked) strobes. Legal range 1..7.

Ports (`N` = 0 or 1):
- `i_clk`  in  1  system clock; all logic is on its rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_mN_cyc`, `i_mN_stb`, `i_mN_we`  in  1 each  master N cycle, strobe and write enable.
- `i_mN_addr`  in  32  master N address.
- `i_mN_data`  in  32  master N write data.
- `i_mN_sel`  in  4  master N byte selects.
- `o_mN_stall`  out  1  stall to master N.
- `o_mN_ack`  out  1  ack to master N.
- `o_mN_err`  out  1  timeout error to master N (one-cycle pulse).
- `o_mN_data`  out  32  read data to master N; equals `i_s_data`, qualified only by `o_mN_ack`.
- `o_s_cyc`, `o_s_stb`, `o_s_we`  out  1 each  to the slave decoder.
- `o_s_addr`  out  32  to the slave decoder.
- `o_s_data`  out  32  to the slave decoder.
- `o_s_sel`  out  4  to the slave decoder.
- `i_s_stall`, `i_s_ack`  in  1 each  from the slave decoder.
- `i_s_data`  in  32  from the slave decoder.
- `o_grant`  out  2  one-hot current owner; 00 when idle.
- `o_timeout`  out  1  one-cycle pulse when an abort fires.

## Operation

**FSM states:** IDLE, OWN0, OWN1, ABORT.

**Registers:**
- `state`
- `last` (last served master)
- `outstanding` (3-bit)
- `tcount` (16-bit)

**IDLE**
- `o_s_cyc` = 0 and `o_s_stb` = 0.
- Both `o_mN_stall` = 1.
- On the next edge:
  - Only `i_m0_cyc` high: go to OWN0.
  - Only `i_m1_cyc` high: go to OWN1.
  - Both high: grant the master ≠ `last`.
- `last` is updated on entry to OWNn.

**OWNn**
- The slave bus is a combinational mux of master n:
  - `o_s_cyc` = `i_mn_cyc`.
  - `o_s_stb` = `i_mn_stb` & (`outstanding` < `MAX_OUT`).
  - `o_s_we`, `o_s_addr`, `o_s_data`, `o_s_sel` come from master n.
- `o_mn_stall` = `i_s_stall` | (`outstanding` == `MAX_OUT`).
- `o_mn_ack` = `i_s_ack`.
- The other master sees stall = 1, ack = 0, err = 0.

**Outstanding counter**
- +1 on an accepted strobe (`o_s_stb` & !`i_s_stall`).
- −1 on `i_s_ack`.
- Both in the same cycle: unchanged.
- An ack while `outstanding` = 0 is ignored (no underflow).

**Timeout counter**
- `tcount` clears on any `i_s_ack` and whenever `outstanding` = 0.
- Otherwise it increments.
- Reaching `TIMEOUT` − 1 moves the FSM to ABORT.

**Release**
- `i_mn_cyc` low while in OWNn moves the FSM to IDLE at the next edge.
- `outstanding` and `tcount` are cleared on release.
- Dropping `cyc` with transfers still outstanding is legal Wishbone abandonment; late acks in IDLE are not forwarded.

**ABORT (exactly one cycle)**
- `o_s_cyc` = 0.
- `o_mn_err` = 1 and `o_timeout` = 1.
- `o_mn_stall` = 1.
- `outstanding` and `tcount` are cleared.
- Next state is IDLE.

**Reset:**
- `state` = IDLE.
- `last` = 1, so master 0 (CPU) wins the first tie.
- Counters = 0.
- All outputs 0, except both `o_mN_stall` = 1.
- Reset is honoured in any state, including mid-burst.

## Timing
- Grant latency: `cyc` seen in IDLE at edge k gives `o_s_cyc` high in cycle k+1; the first strobe can be accepted in cycle k+1.
- Slave-path signals are combinational through the mux; arbiter latency is zero once owned.
- Release: at least one IDLE cycle separates consecutive grants, so the slave decoder always sees `o_s_cyc` drop between owners.
- Ownership handover on contention alternates 0, 1, 0, 1…; a single requester may be re-granted back-to-back with a one-cycle gap.
- Abort: the error pulse comes exactly `TIMEOUT` cycles after the last progress event (accepted strobe with nothing pending, or ack), followed by one ABORT cycle.
- Timeout precedence: if `i_s_ack` arrives in the same cycle that `tcount` would reach `TIMEOUT` − 1, the ack wins and no abort occurs.
- `o_grant` is registered from `state` (OWN0 → 01, OWN1 → 10, others → 00).

## Test plan
- **Reset and single CPU read:** hold `i_rst` 3 cycles; check every `o_s_*` = 0 and stalls = 1. Then m0 reads 0x0000_0100 with the slave acking after 2 cycles with 0xDEADBEEF → `o_grant` = 01 one cycle after `cyc`, `o_m0_ack` with data 0xDEADBEEF, IDLE one cycle after `cyc` drops.
- **Contention fairness:** both masters hold `cyc` continuously, each doing one write and then dropping `cyc` for 1 cycle → grant sequence 01, 10, 01, 10, with one IDLE cycle between grants.
- **Pipelined burst with `MAX_OUT` = 2:** m1 issues 4 strobes and the slave delays acks → `o_m1_stall` is forced high while `outstanding` = 2; all 4 acks are delivered and the counter ends at 0.
- **Timeout with `TIMEOUT` = 16:** m0 strobe accepted, no ack → `o_m0_err` and `o_timeout` pulse 16 cycles later; `o_s_cyc` is low that cycle; m1 is granted next if requesting.
- **Ack at timeout boundary:** ack arrives exactly at `tcount` = 15 → no err, normal ack.
- **Reset mid-operation:** assert `i_rst` during OWN1 with 2 transfers outstanding → next cycle all outputs are at reset values and a following m0 request is granted first.
